dac_share_arbiter: RTL and testbench
====================================

# dac_share_arbiter

Round-robin arbiter that shares the single AD9748 DAC bus among up to `_NUM_CHANNELS` pattern generators. It sits between the per-channel pattern engines and the top-level `dac_data` pins, in the 50 MHz domain. It grants one requester at a time and registers that requester's sample onto the DAC. Between owners it inserts a configurable dead gap at idle code. It force-releases any owner that exceeds a hold limit.

## Interface
Parameters:
- `_NUM_CHANNELS`, default 4 — number of requesters; legal range 2..8.
- `_DAC_WIDTH`, default 8 — DAC sample width.
- `_IDLE_CODE`, default 8'h80 — code driven when no channel owns the DAC (mid-scale).
- `_MAX_HOLD`, default 16'd1000 — maximum number of consecutive grant cycles; legal range 1..65535.
- `_GAP`, default 2 — dead cycles between grants; legal range 1..255.

Ports:
- `clk`  in  1 — system clock (`clk_50M`).
- `rst_n`  in  1 — asynchronous active-low reset.
- `req`  in  `_NUM_CHANNELS` — per-channel request; a channel holds it high while it wants the DAC.
- `ch_data`  in  `_NUM_CHANNELS*_DAC_WIDTH` — flattened samples; channel i occupies bits [i*W +: W].
- `grant`  out  `_NUM_CHANNELS` — one-hot or zero; registered.
- `dac_data`  out  `_DAC_WIDTH` — registered DAC code.
- `dac_busy`  out  1 — high while in GRANT.
- `owner_id`  out  8 — index of the current or last owner; registered.
- `timeout`  out  1 — one-cycle pulse when the hold limit forces a release.

## Operation
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If `req` is nonzero, select the winner by round robin, starting from `owner_id+1` and wrapping modulo `_NUM_CHANNELS`.
  - On the next edge, enter GRANT: `grant` = onehot(winner), `owner_id` = winner, hold counter = 0.
- GRANT:
  - Every cycle, `dac_data` <= `ch_data[owner_id]`.
  - The hold counter increments each cycle and saturates at 16 bits.
- GRANT exit:
  - Voluntary release: `req[owner_id]` low → go to GAP.
  - Forced release: hold counter == `_MAX_HOLD-1` with the request still high → go to GAP and pulse `timeout`.
- GAP:
  - `grant` = 0, `dac_data` = `_IDLE_CODE`, gap counter counts `_GAP` cycles, then go to IDLE.
  - Requests arriving during GAP are held pending and evaluated in IDLE.
- A force-released channel competes normally. Round robin therefore serves any other pending requester first. If it is the only requester, it is re-granted after GAP + 1 IDLE cycle.
- Requests from channels other than the owner never pre-empt the owner.
- Only `req[owner_id]` matters in GRANT; other `req` bits are ignored until IDLE.
- `ch_data` of non-owners is ignored.
- Reset (asynchronous, any state):
  - State = IDLE, `grant` = 0, `dac_data` = `_IDLE_CODE`, `dac_busy` = 0, `timeout` = 0.
  - `owner_id` = `_NUM_CHANNELS-1`, so the first arbitration starts at channel 0.

## Timing
- `req` rises in IDLE at edge N → `grant` and `dac_busy` high after edge N+1.
- First owner sample: `ch_data` presented in cycle N+1 appears on `dac_data` after edge N+2. Sample latency is 1 cycle for the whole grant.
- Owner drops `req`, sampled at edge M → `grant` and `dac_busy` low and `dac_data` = `_IDLE_CODE` after edge M.
- GAP occupies `_GAP` cycles, then IDLE lasts at least 1 cycle.
- Minimum request-to-grant turnaround between owners is `_GAP` + 2 cycles.
- A grant lasts at most `_MAX_HOLD` cycles. `timeout` is high in the first GAP cycle only.
- Simultaneous release and timeout on the same edge counts as a voluntary release: no `timeout` pulse.
- `grant` is never multi-hot. `grant` and `dac_busy` change on the same edge.

## Test plan
- Reset: hold `rst_n` = 0 with `req` = 4'hF. Expect `grant` = 0, `dac_data` = 8'h80, `owner_id` = 3. Release reset: channel 0 is granted 2 edges later.
- Single owner: `req[2]` high for 10 cycles with `ch_data[2]` ramping 0..9. Expect `dac_data` to follow the ramp 1 cycle late. On release, 2 cycles of 8'h80, then IDLE.
- Round robin: `req` = 4'hF held, each owner releases after 5 cycles. Grant order is 0,1,2,3,0, each grant separated by 2 gap cycles plus 1 idle cycle.
- Timeout: set `_MAX_HOLD` = 8, `req[1]` high forever and `req[3]` high. Expect `timeout` pulse after 8 grant cycles, then `grant` = 4'b1000. Repeat with only `req[1]`: re-granted after 3 cycles.
- Mid-grant reset: assert `rst_n` low asynchronously during GRANT. Expect `grant`, `dac_data`, and `dac_busy` at reset values immediately, without waiting for a clock edge.
- Boundary: request rises in the last GAP cycle → granted after exactly one IDLE cycle. Release and timeout on the same edge → no `timeout` pulse.

Source files
------------

// File: rtl/dac_share_arbiter.sv
// Round-robin owner arbitration for the shared DAC bus.
// Inserts an idle-code dead gap between owners and force-releases long holds.
module dac_share_arbiter #(
  parameter int unsigned            _NUM_CHANNELS = 4,
  parameter int unsigned            _DAC_WIDTH    = 8,
  parameter logic [_DAC_WIDTH-1:0]  _IDLE_CODE    = 8'h80,
  parameter logic [15:0]            _MAX_HOLD     = 16'd1000,
  parameter int unsigned            _GAP          = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [_NUM_CHANNELS-1:0]             req,
  input  logic [_NUM_CHANNELS*_DAC_WIDTH-1:0]  ch_data,
  output logic [_NUM_CHANNELS-1:0]             grant,
  output logic [_DAC_WIDTH-1:0]                dac_data,
  output logic                                 dac_busy,
  output logic [7:0]                           owner_id,
  output logic                                 timeout
);

  localparam int unsigned N      = _NUM_CHANNELS;
  localparam int unsigned W      = _DAC_WIDTH;
  localparam int          NCH    = int'(_NUM_CHANNELS);
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned GAP_W  = 8;
  localparam int unsigned HOLD_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        grant_d;
  logic [W-1:0]        dac_d;
  logic                busy_d;
  logic [7:0]          owner_d;
  logic                timeout_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [GAP_W-1:0]    gap_q, gap_d;

  logic [W-1:0]        samples [N];
  logic [IDX_W-1:0]    owner_idx;
  logic [W-1:0]        owner_sample;
  logic                owner_req;
  logic [IDX_W-1:0]    cand;
  logic [IDX_W-1:0]    winner;
  logic                win_valid;

  // Unpack the flattened per-channel samples.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      samples[i] = ch_data[i*int'(W) +: W];
    end
  end

  assign owner_idx    = owner_id[IDX_W-1:0];
  assign owner_sample = samples[owner_idx];
  assign owner_req    = req[owner_idx];

  // Round-robin search starting just after the last owner.
  always_comb begin
    win_valid = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = IDX_W'((int'(owner_id) + k) % NCH);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        winner    = cand;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant;
    dac_d     = dac_data;
    busy_d    = dac_busy;
    owner_d   = owner_id;
    timeout_d = 1'b0;
    hold_d    = hold_q;
    gap_d     = gap_q;

    unique case (state_q)
      S_IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        dac_d   = _IDLE_CODE;
        if (win_valid) begin
          state_d = S_GRANT;
          grant_d = N'(1) << winner;
          busy_d  = 1'b1;
          owner_d = 8'(winner);
          hold_d  = '0;
        end
      end

      S_GRANT: begin
        // A release on the limit edge wins over the forced release.
        if (!owner_req || (hold_q == _MAX_HOLD - 16'd1)) begin
          state_d   = S_GAP;
          grant_d   = '0;
          busy_d    = 1'b0;
          dac_d     = _IDLE_CODE;
          gap_d     = '0;
          timeout_d = owner_req;
        end else begin
          dac_d = owner_sample;
          if (hold_q != '1) begin
            hold_d = hold_q + 16'd1;
          end
        end
      end

      S_GAP: begin
        grant_d = '0;
        busy_d  = 1'b0;
        dac_d   = _IDLE_CODE;
        if (gap_q == GAP_W'(_GAP - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        dac_d   = _IDLE_CODE;
      end
    endcase
  end

  // State and output registers; owner resets to the top channel so channel 0 is served first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      grant    <= '0;
      dac_data <= _IDLE_CODE;
      dac_busy <= 1'b0;
      owner_id <= 8'(N - 1);
      timeout  <= 1'b0;
      hold_q   <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant    <= grant_d;
      dac_data <= dac_d;
      dac_busy <= busy_d;
      owner_id <= owner_d;
      timeout  <= timeout_d;
      hold_q   <= hold_d;
      gap_q    <= gap_d;
    end
  end

endmodule

// File: tb/tb_dac_share_arbiter.sv
// Directed bench for dac_share_arbiter: vector table plus multi-cycle sequences.
// A second instance with a short hold limit exercises forced release.
module tb_dac_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] ch_data;
  logic [3:0]  grant;
  logic [7:0]  dac_data;
  logic        dac_busy;
  logic [7:0]  owner_id;
  logic        timeout;

  logic [3:0]  req_t;
  logic [31:0] ch_data_t;
  logic [3:0]  grant_t;
  logic [7:0]  dac_data_t;
  logic        dac_busy_t;
  logic [7:0]  owner_id_t;
  logic        timeout_t;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [7:0]  dac;
    logic        busy;
    logic [7:0]  owner;
  } vec_t;

  vec_t vecs[$];

  dac_share_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .ch_data  (ch_data),
    .grant    (grant),
    .dac_data (dac_data),
    .dac_busy (dac_busy),
    .owner_id (owner_id),
    .timeout  (timeout)
  );

  dac_share_arbiter #(._MAX_HOLD(16'd8)) dut_to (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_t),
    .ch_data  (ch_data_t),
    .grant    (grant_t),
    .dac_data (dac_data_t),
    .dac_busy (dac_busy_t),
    .owner_id (owner_id_t),
    .timeout  (timeout_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic [7:0] c0, input logic [7:0] c2,
                              input logic [3:0] g, input logic [7:0] d, input logic b,
                              input logic [7:0] o);
    vec_t v;
    v.req   = r;
    v.data  = {8'h3C, c2, 8'h3C, c0};
    v.grant = g;
    v.dac   = d;
    v.busy  = b;
    v.owner = o;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    logic [3:0] oh;

    n_cmp = 0;
    n_bad = 0;

    // v0..v4: grant ch0, release, then a request raised in the last gap cycle
    vecs.push_back(mk(4'hF, 8'h00, 8'h00, 4'h1, 8'h80, 1'b1, 8'd0));
    vecs.push_back(mk(4'hF, 8'h11, 8'h00, 4'h1, 8'h11, 1'b1, 8'd0));
    vecs.push_back(mk(4'hE, 8'h22, 8'h00, 4'h0, 8'h80, 1'b0, 8'd0));
    vecs.push_back(mk(4'h0, 8'h33, 8'h00, 4'h0, 8'h80, 1'b0, 8'd0));
    vecs.push_back(mk(4'h4, 8'h00, 8'h00, 4'h0, 8'h80, 1'b0, 8'd0));
    // v5..v15: ch2 owns, ramp 0..9 one cycle late; other requests do not pre-empt
    vecs.push_back(mk(4'h4, 8'h00, 8'hA5, 4'h4, 8'h80, 1'b1, 8'd2));
    for (int k = 0; k < 10; k++) begin
      vecs.push_back(mk((k >= 2) ? 4'hF : 4'h4, 8'h99, 8'(k), 4'h4, 8'(k), 1'b1, 8'd2));
    end
    // v16..v23: release into gap, then ch3 wins over ch0 (search starts after ch2)
    vecs.push_back(mk(4'hB, 8'h00, 8'hEE, 4'h0, 8'h80, 1'b0, 8'd2));
    vecs.push_back(mk(4'hB, 8'h00, 8'hEE, 4'h0, 8'h80, 1'b0, 8'd2));
    vecs.push_back(mk(4'hB, 8'h00, 8'hEE, 4'h0, 8'h80, 1'b0, 8'd2));
    vecs.push_back(mk(4'hB, 8'h00, 8'h00, 4'h8, 8'h80, 1'b1, 8'd3));
    vecs.push_back(mk(4'h3, 8'h00, 8'h00, 4'h0, 8'h80, 1'b0, 8'd3));
    vecs.push_back(mk(4'h0, 8'h00, 8'h00, 4'h0, 8'h80, 1'b0, 8'd3));
    vecs.push_back(mk(4'h0, 8'h00, 8'h00, 4'h0, 8'h80, 1'b0, 8'd3));
    vecs.push_back(mk(4'h0, 8'h00, 8'h00, 4'h0, 8'h80, 1'b0, 8'd3));

    // Reset with all requests asserted
    rst_n     = 1'b0;
    req       = 4'hF;
    ch_data   = 32'h0;
    req_t     = 4'h0;
    ch_data_t = 32'h0;
    #12;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_dac", 32'(dac_data), 32'h80);
    check("rst_owner", 32'(owner_id), 32'd3);
    check("rst_busy", 32'(dac_busy), 32'h0);
    check("rst_timeout", 32'(timeout), 32'h0);
    step();
    step();
    check("rst_hold_grant", 32'(grant), 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      req     = vecs[i].req;
      ch_data = vecs[i].data;
      step();
      check($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
      check($sformatf("v%0d_dac", i), 32'(dac_data), 32'(vecs[i].dac));
      check($sformatf("v%0d_busy", i), 32'(dac_busy), 32'(vecs[i].busy));
      check($sformatf("v%0d_owner", i), 32'(owner_id), 32'(vecs[i].owner));
      check($sformatf("v%0d_timeout", i), 32'(timeout), 32'h0);
    end

    // Asynchronous reset in the middle of a grant
    req     = 4'h2;
    ch_data = 32'h0000_7700;
    step();
    step();
    check("mid_pre_grant", 32'(grant), 32'h2);
    check("mid_pre_dac", 32'(dac_data), 32'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_dac", 32'(dac_data), 32'h80);
    check("mid_rst_busy", 32'(dac_busy), 32'h0);
    check("mid_rst_owner", 32'(owner_id), 32'd3);
    req = 4'hF;
    step();
    step();
    rst_n = 1'b1;

    // Round robin with all requests held, each owner releasing after 5 cycles
    for (int i = 0; i < 5; i++) begin
      oh = 4'b0001 << (i % 4);
      waited = 0;
      while (grant == 4'h0 && waited < 10) begin
        step();
        waited++;
      end
      check($sformatf("rr%0d_wait", i), 32'(waited), (i == 0) ? 32'd1 : 32'd3);
      check($sformatf("rr%0d_grant", i), 32'(grant), 32'(oh));
      check($sformatf("rr%0d_busy", i), 32'(dac_busy), 32'h1);
      check($sformatf("rr%0d_owner", i), 32'(owner_id), 32'(i % 4));
      repeat (4) step();
      check($sformatf("rr%0d_hold", i), 32'(grant), 32'(oh));
      req = 4'hF & ~oh;
      step();
      check($sformatf("rr%0d_release", i), 32'(grant), 32'h0);
      check($sformatf("rr%0d_no_timeout", i), 32'(timeout), 32'h0);
      req = 4'hF;
    end
    req = 4'h0;

    // Forced release with a competing requester (hold limit 8)
    req_t     = 4'b1010;
    ch_data_t = 32'h0000_5A00;
    step();
    check("to_first_grant", 32'(grant_t), 32'h2);
    for (int k = 1; k <= 7; k++) begin
      step();
      check($sformatf("to_hold%0d_timeout", k), 32'(timeout_t), 32'h0);
    end
    check("to_hold_grant", 32'(grant_t), 32'h2);
    check("to_hold_dac", 32'(dac_data_t), 32'h5A);
    step();
    check("to_force_grant", 32'(grant_t), 32'h0);
    check("to_force_pulse", 32'(timeout_t), 32'h1);
    check("to_force_busy", 32'(dac_busy_t), 32'h0);
    check("to_force_dac", 32'(dac_data_t), 32'h80);
    step();
    check("to_pulse_end", 32'(timeout_t), 32'h0);
    step();
    check("to_idle_grant", 32'(grant_t), 32'h0);
    step();
    check("to_next_grant", 32'(grant_t), 32'h8);
    check("to_next_owner", 32'(owner_id_t), 32'd3);

    // ch3 releases voluntarily; ch1 alone then times out and is re-granted
    req_t = 4'b0010;
    step();
    check("to_vol_grant", 32'(grant_t), 32'h0);
    check("to_vol_timeout", 32'(timeout_t), 32'h0);
    step();
    step();
    check("to_solo_idle", 32'(grant_t), 32'h0);
    step();
    check("to_solo_grant", 32'(grant_t), 32'h2);
    repeat (7) step();
    step();
    check("to_solo_force", 32'(grant_t), 32'h0);
    check("to_solo_pulse", 32'(timeout_t), 32'h1);
    step();
    check("to_regrant_gap1", 32'(grant_t), 32'h0);
    step();
    check("to_regrant_gap2", 32'(grant_t), 32'h0);
    step();
    check("to_regrant", 32'(grant_t), 32'h2);
    check("to_regrant_owner", 32'(owner_id_t), 32'd1);

    // Release on the same edge the limit is reached: no pulse
    repeat (7) step();
    req_t = 4'b0000;
    step();
    check("to_tie_grant", 32'(grant_t), 32'h0);
    check("to_tie_timeout", 32'(timeout_t), 32'h0);
    step();
    check("to_tie_timeout_next", 32'(timeout_t), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
